// File: rtl/serial_parity_rx.sv
// Asynchronous-serial frame receiver: start bit, DATA_WIDTH data bits LSB first,
// one parity bit, one stop bit. Parity is captured only; checking happens downstream.
module serial_parity_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  parity_out,
    output logic                  valid_out,
    output logic                  frame_err_out,
    output logic                  busy_out
);

    localparam int H     = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t                  state;
    logic                    rx_meta;
    logic                    rxs;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   shift;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic                    par_hold;

    // First bit on the line ends up in bit 0 after DATA_WIDTH right shifts.
    always_comb begin
        shift_next                 = shift >> 1;
        shift_next[DATA_WIDTH-1]   = rxs;
    end

    assign busy_out = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rxs           <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            par_hold      <= 1'b0;
            data_out      <= '0;
            parity_out    <= 1'b0;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            rx_meta       <= rx_in;
            rxs           <= rx_meta;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                // A line that is high again at mid-start was a glitch.
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shift <= shift_next;
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= PARITY;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        par_hold <= rxs;
                        state    <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Returning to IDLE on the stop sample lets a back-to-back start bit be caught.
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            data_out   <= shift;
                            parity_out <= par_hold;
                            valid_out  <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_err_out <= 1'b1;
                            state         <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: directed scenarios plus random frames, checked against
// expected pulse records derived from the frame timing rules.
module tb_serial_parity_rx;

    localparam int W   = 8;
    localparam int C   = 16;
    localparam int H   = C / 2;
    localparam int LAT = 2 + H + (W + 2) * C;
    localparam int EW  = W + 34;

    localparam int SW   = 5;
    localparam int SC   = 4;
    localparam int SLAT = 2 + SC / 2 + (SW + 2) * SC;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_in;
    logic [W-1:0] data_out;
    logic         parity_out;
    logic         valid_out;
    logic         frame_err_out;
    logic         busy_out;

    logic          rx_s;
    logic [SW-1:0] data_s;
    logic          par_s;
    logic          valid_s;
    logic          ferr_s;
    logic          busy_s;

    int total  = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    // Expected pulse record: {is_valid, edge, parity_out, data_out}
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  last_good = '0;
    logic          last_par  = 1'b0;

    int            s_cnt  = 0;
    int            s_ferr = 0;
    int            s_cyc  = 0;
    logic [SW-1:0] s_data = '0;
    logic          s_par  = 1'b0;

    serial_parity_rx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_in         (rx_in),
        .data_out      (data_out),
        .parity_out    (parity_out),
        .valid_out     (valid_out),
        .frame_err_out (frame_err_out),
        .busy_out      (busy_out)
    );

    serial_parity_rx #(.DATA_WIDTH(SW), .CLKS_PER_BIT(SC)) dut_small (
        .clk           (clk),
        .rst           (rst),
        .rx_in         (rx_s),
        .data_out      (data_s),
        .parity_out    (par_s),
        .valid_out     (valid_s),
        .frame_err_out (ferr_s),
        .busy_out      (busy_s)
    );

    // Clock and edge counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Driver tasks: all start and end 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic goto_neg(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (cyc < k && n < 100000) begin
            @(negedge clk);
            n++;
        end
        chk("goto_cycle", cyc, k);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic p, input logic stop_bit,
                              input int extra_low);
        logic [W+1:0] bits;
        int           start;
        start = cyc + 1;
        bits  = {stop_bit, p, d};
        if (stop_bit) begin
            exp_q.push_back({1'b1, 32'(start + LAT), p, d});
            last_good = d;
            last_par  = p;
        end else begin
            exp_q.push_back({1'b0, 32'(start + LAT), last_par, last_good});
        end
        rx_in = 1'b0;
        tick(C);
        for (int i = 0; i < W + 2; i++) begin
            rx_in = bits[i];
            tick(C);
        end
        if (!stop_bit) begin
            tick(extra_low);
            rx_in = 1'b1;
        end
    endtask

    // Scoreboard: every pulse must match the oldest expected record.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (valid_out || frame_err_out) begin
            chk("pulse_exclusive", 32'(valid_out & frame_err_out), 32'd0);
            total++;
            assert (exp_q.size() > 0) passes++;
            else begin
                fails++;
                $error("FAIL unexpected_pulse: observed pulse at edge %0d expected none", cyc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pulse_kind",  32'(valid_out), 32'(e[EW-1]));
                chk("pulse_edge",  cyc, e[W+32 -: 32]);
                chk("data_out",    32'(data_out), 32'(e[W-1:0]));
                chk("parity_out",  32'(parity_out), 32'(e[W]));
            end
        end
    end

    always @(negedge clk) begin
        if (valid_s) begin
            s_cnt  <= s_cnt + 1;
            s_cyc  <= cyc;
            s_data <= data_s;
            s_par  <= par_s;
        end
        if (ferr_s) s_ferr <= s_ferr + 1;
    end

    initial begin
        int            k;
        int            start;
        logic [W-1:0]  rd;
        logic          rp;
        logic [7:0]    sbits;

        rst   = 1'b1;
        rx_in = 1'b1;
        rx_s  = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data_out",   32'(data_out), 32'd0);
        chk("rst_parity_out", 32'(parity_out), 32'd0);
        chk("rst_valid_out",  32'(valid_out), 32'd0);
        chk("rst_frame_err",  32'(frame_err_out), 32'd0);
        chk("rst_busy_out",   32'(busy_out), 32'd0);
        @(posedge clk);
        #2;
        tick(5);

        send_frame(8'h54, 1'b1, 1'b1, 0);
        tick(10);

        send_frame(8'hFF, 1'b0, 1'b1, 0);
        send_frame(8'h01, 1'b0, 1'b1, 0);
        tick(10);

        k = cyc;
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        goto_neg(k + 10);
        chk("glitch_busy_before", 32'(busy_out), 32'd1);
        goto_neg(k + 11);
        chk("glitch_busy_after", 32'(busy_out), 32'd0);
        @(posedge clk);
        #2;
        tick(20);
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        tick(10);

        send_frame(8'h3C, 1'b1, 1'b0, 40);
        k = cyc;
        goto_neg(k + 2);
        chk("break_busy_held", 32'(busy_out), 32'd1);
        chk("break_data_kept", 32'(data_out), 32'(8'hA5));
        goto_neg(k + 3);
        chk("break_busy_release", 32'(busy_out), 32'd0);
        @(posedge clk);
        #2;
        tick(5);
        send_frame(8'h0F, 1'b0, 1'b1, 0);
        tick(10);

        rd    = 8'hC6;
        rx_in = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rx_in = rd[i];
            tick(C);
        end
        rx_in = rd[4];
        tick(H);
        rx_in = 1'b1;
        rst   = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_data_out",   32'(data_out), 32'd0);
        chk("abort_parity_out", 32'(parity_out), 32'd0);
        chk("abort_valid_out",  32'(valid_out), 32'd0);
        chk("abort_frame_err",  32'(frame_err_out), 32'd0);
        chk("abort_busy_out",   32'(busy_out), 32'd0);
        @(posedge clk);
        #2;
        last_good = '0;
        last_par  = 1'b0;
        tick(20);
        send_frame(8'h81, 1'b1, 1'b1, 0);
        tick(10);

        for (int i = 0; i < 6; i++) begin
            rd = W'($urandom());
            rp = 1'($urandom_range(0, 1));
            send_frame(rd, rp, 1'b1, 0);
            tick($urandom_range(0, 20));
        end

        tick(LAT + 30);
        chk("expected_drained", exp_q.size(), 32'd0);

        start = cyc + 1;
        sbits = {1'b0, 1'b1, 1'b0, 5'h15};
        rx_s  = 1'b0;
        tick(SC);
        for (int i = 0; i < SW + 2; i++) begin
            rx_s = sbits[i];
            tick(SC);
        end
        rx_s = 1'b1;
        tick(20);
        chk("small_valid_count", s_cnt, 32'd1);
        chk("small_valid_edge",  s_cyc, 32'(start + SLAT));
        chk("small_data_out",    32'(s_data), 32'(5'h15));
        chk("small_parity_out",  32'(s_par), 32'd0);
        chk("small_frame_err",   s_ferr, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
